// File: rtl/ycbcr_csd_pkg.sv
// Shared types and fixed-point constants for the streaming RGB->YCbCr converter.
// Coefficients are Q16; rows are ordered Y, Cb, Cr and columns are R, G, B.
package ycbcr_csd_pkg;

    typedef enum logic {
        MODE_FULL   = 1'b0,
        MODE_STUDIO = 1'b1
    } mode_e;

    localparam int ACC_W = 8 + 16 + 3;
    localparam int NCOEF = 9;

    localparam int COEF_FULL [NCOEF] = '{
        19595,  38470,   7471,
       -11058, -21710,  32768,
        32768, -27439,  -5329
    };

    // Studio chroma is the full-range set scaled by 224/255.
    // The Cb R term is trimmed by one LSB so each chroma row sums to zero,
    // which makes gray inputs land exactly on 128.
    localparam int COEF_STUDIO [NCOEF] = '{
        16829,  33039,   6416,
        -9713, -19071,  28784,
        28784, -24103,  -4681
    };

    localparam int OFF_FULL   [3] = '{0, 128, 128};
    localparam int OFF_STUDIO [3] = '{16, 128, 128};

endpackage

// File: rtl/ycbcr_csd_stream_if.sv
// Pixel stream bundle: RGB input beats in, YCbCr output beats out,
// each side with its own valid/ready pair and sof/eol sideband.
interface ycbcr_csd_stream_if #(
    parameter int LANES = 1,
    parameter int IW    = 8,
    parameter int OW    = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sof;
    logic                  in_eol;
    logic                  range_sel;
    logic [LANES*IW-1:0]   r_in;
    logic [LANES*IW-1:0]   g_in;
    logic [LANES*IW-1:0]   b_in;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sof;
    logic                  out_eol;
    logic [LANES*OW-1:0]   y_out;
    logic [LANES*OW-1:0]   cb_out;
    logic [LANES*OW-1:0]   cr_out;

    modport slave (
        input  in_valid, in_sof, in_eol, range_sel,
        input  r_in, g_in, b_in, out_ready,
        output in_ready, out_valid, out_sof, out_eol,
        output y_out, cb_out, cr_out
    );

    modport master (
        output in_valid, in_sof, in_eol, range_sel,
        output r_in, g_in, b_in, out_ready,
        input  in_ready, out_valid, out_sof, out_eol,
        input  y_out, cb_out, cr_out
    );

endinterface

// File: rtl/ycbcr_csd_lane.sv
// One pixel's datapath: input regs, CSD partial products, then
// sum + offset + round + saturate. Stage enables come from the top.
import ycbcr_csd_pkg::*;

module ycbcr_csd_lane #(
    parameter int IW    = 8,
    parameter int SCALE = 16,
    parameter int OW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en1_i,
    input  logic          en2_i,
    input  logic          en3_i,
    input  mode_e         mode1_i,
    input  mode_e         mode2_i,
    input  logic [IW-1:0] r_i,
    input  logic [IW-1:0] g_i,
    input  logic [IW-1:0] b_i,
    output logic [OW-1:0] y_o,
    output logic [OW-1:0] cb_o,
    output logic [OW-1:0] cr_o
);

    localparam int AW = (IW + SCALE + 3 > ACC_W) ? IW + SCALE + 3 : ACC_W;

    typedef logic signed [AW-1:0] acc_t;

    logic [IW-1:0] r_q, g_q, b_q;
    acc_t          pp_d [NCOEF];
    acc_t          pp_q [NCOEF];
    logic [OW-1:0] y_d, cb_d, cr_d;
    logic [OW-1:0] y_q, cb_q, cr_q;

    // Constant c is recoded to signed digits on the fly; with c fixed per
    // call this folds to a handful of shifted adds/subtracts of x.
    function automatic acc_t csd_mul(input logic [IW-1:0] x, input int c);
        acc_t acc;
        acc_t xs;
        int   n;
        acc = '0;
        xs  = acc_t'(x);
        n   = c;
        for (int i = 0; i < SCALE + 2; i++) begin
            if (n[1:0] == 2'b01) begin
                acc = acc + (xs <<< i);
                n   = n - 1;
            end else if (n[1:0] == 2'b11) begin
                acc = acc - (xs <<< i);
                n   = n + 1;
            end
            n = n >>> 1;
        end
        return acc;
    endfunction

    function automatic logic [OW-1:0] rnd_sat(
        input acc_t a,
        input acc_t b,
        input acc_t c,
        input int   off
    );
        acc_t s;
        s = a + b + c + (acc_t'(off) <<< SCALE) + (acc_t'(1) <<< (SCALE - 1));
        s = s >>> SCALE;
        if (s < 0) return '0;
        if (s > acc_t'((1 << OW) - 1)) return '1;
        return s[OW-1:0];
    endfunction

    always_comb begin
        for (int j = 0; j < NCOEF; j++) begin
            pp_d[j] = (mode1_i == MODE_STUDIO)
                ? csd_mul((j % 3 == 0) ? r_q : (j % 3 == 1) ? g_q : b_q,
                          COEF_STUDIO[j])
                : csd_mul((j % 3 == 0) ? r_q : (j % 3 == 1) ? g_q : b_q,
                          COEF_FULL[j]);
        end
    end

    always_comb begin
        y_d  = rnd_sat(pp_q[0], pp_q[1], pp_q[2],
                       (mode2_i == MODE_STUDIO) ? OFF_STUDIO[0] : OFF_FULL[0]);
        cb_d = rnd_sat(pp_q[3], pp_q[4], pp_q[5],
                       (mode2_i == MODE_STUDIO) ? OFF_STUDIO[1] : OFF_FULL[1]);
        cr_d = rnd_sat(pp_q[6], pp_q[7], pp_q[8],
                       (mode2_i == MODE_STUDIO) ? OFF_STUDIO[2] : OFF_FULL[2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            for (int j = 0; j < NCOEF; j++) pp_q[j] <= '0;
            y_q  <= '0;
            cb_q <= '0;
            cr_q <= '0;
        end else begin
            if (en1_i) begin
                r_q <= r_i;
                g_q <= g_i;
                b_q <= b_i;
            end
            if (en2_i) pp_q <= pp_d;
            if (en3_i) begin
                y_q  <= y_d;
                cb_q <= cb_d;
                cr_q <= cr_d;
            end
        end
    end

    assign y_o  = y_q;
    assign cb_o = cb_q;
    assign cr_o = cr_q;

endmodule

// File: rtl/ycbcr_csd_stream.sv
// Streaming RGB->YCbCr converter: 3-stage elastic pipeline over LANES
// pixel lanes, with per-frame range mode carried alongside each beat.
import ycbcr_csd_pkg::*;

module ycbcr_csd_stream #(
    parameter int LANES       = 1,
    parameter int INPUT_WIDTH = 8,
    parameter int SCALE       = 16,
    parameter int OUT_WIDTH   = 8
) (
    input logic              clk,
    input logic              rst_n,
    ycbcr_csd_stream_if.slave bus
);

    logic  v1_q, v2_q, v3_q;
    logic  v1_d, v2_d, v3_d;
    logic  ld1, ld2, ld3;
    logic  accept;
    logic  en2, en3;
    mode_e mode_q, mode_d;
    mode_e m1_q, m2_q;
    logic  sof1_q, sof2_q, sof3_q;
    logic  eol1_q, eol2_q, eol3_q;

    logic [LANES*OUT_WIDTH-1:0] y_w, cb_w, cr_w;

    // A stage may load when empty or when the stage after it is loading,
    // so bubbles collapse and in_ready never looks at in_valid.
    always_comb begin
        ld3    = !v3_q || bus.out_ready;
        ld2    = !v2_q || ld3;
        ld1    = !v1_q || ld2;
        accept = ld1 && bus.in_valid;
        en2    = ld2 && v1_q;
        en3    = ld3 && v2_q;
        v1_d   = ld1 ? bus.in_valid : v1_q;
        v2_d   = ld2 ? v1_q : v2_q;
        v3_d   = ld3 ? v2_q : v3_q;
        mode_d = bus.in_sof ? mode_e'(bus.range_sel) : mode_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            mode_q <= MODE_FULL;
            m1_q   <= MODE_FULL;
            m2_q   <= MODE_FULL;
            sof1_q <= 1'b0;
            sof2_q <= 1'b0;
            sof3_q <= 1'b0;
            eol1_q <= 1'b0;
            eol2_q <= 1'b0;
            eol3_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (accept) begin
                mode_q <= mode_d;
                m1_q   <= mode_d;
                sof1_q <= bus.in_sof;
                eol1_q <= bus.in_eol;
            end
            if (en2) begin
                m2_q   <= m1_q;
                sof2_q <= sof1_q;
                eol2_q <= eol1_q;
            end
            if (en3) begin
                sof3_q <= sof2_q;
                eol3_q <= eol2_q;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ycbcr_csd_lane #(
            .IW    (INPUT_WIDTH),
            .SCALE (SCALE),
            .OW    (OUT_WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en1_i   (accept),
            .en2_i   (en2),
            .en3_i   (en3),
            .mode1_i (m1_q),
            .mode2_i (m2_q),
            .r_i     (bus.r_in[k*INPUT_WIDTH +: INPUT_WIDTH]),
            .g_i     (bus.g_in[k*INPUT_WIDTH +: INPUT_WIDTH]),
            .b_i     (bus.b_in[k*INPUT_WIDTH +: INPUT_WIDTH]),
            .y_o     (y_w[k*OUT_WIDTH +: OUT_WIDTH]),
            .cb_o    (cb_w[k*OUT_WIDTH +: OUT_WIDTH]),
            .cr_o    (cr_w[k*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    assign bus.in_ready  = ld1;
    assign bus.out_valid = v3_q;
    assign bus.out_sof   = sof3_q;
    assign bus.out_eol   = eol3_q;
    assign bus.y_out     = y_w;
    assign bus.cb_out    = cb_w;
    assign bus.cr_out    = cr_w;

endmodule

// File: tb/tb_ycbcr_csd_stream.sv
// Bench for ycbcr_csd_stream: directed vector table on a 1-lane instance,
// back-pressure scoreboard, a 4-lane beat and a mid-stream reset.
module tb_ycbcr_csd_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ycbcr_csd_stream_if #(.LANES(1), .IW(8), .OW(8)) b1 ();
    ycbcr_csd_stream_if #(.LANES(4), .IW(8), .OW(8)) b4 ();

    ycbcr_csd_stream #(.LANES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    ycbcr_csd_stream #(.LANES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int r, g, b;
        bit sof, rs;
        int y, cb, cr;
    } vec_t;

    typedef struct {
        int y, cb, cr;
        bit sof, eol;
    } exp_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic int conv(input int kr, kg, kb, off, r, g, bl);
        int acc;
        acc = kr * r + kg * g + kb * bl + off * 65536 + 32768;
        acc = acc >>> 16;
        if (acc < 0) return 0;
        if (acc > 255) return 255;
        return acc;
    endfunction

    function automatic void model(input int r, g, bl, input bit st,
                                  output int y, cb, cr);
        y  = st ? conv(16829, 33039, 6416, 16, r, g, bl)
                : conv(19595, 38470, 7471, 0, r, g, bl);
        cb = st ? conv(-9713, -19071, 28784, 128, r, g, bl)
                : conv(-11058, -21710, 32768, 128, r, g, bl);
        cr = st ? conv(28784, -24103, -4681, 128, r, g, bl)
                : conv(32768, -27439, -5329, 128, r, g, bl);
    endfunction

    // Present one beat on the 1-lane bus and wait for an output beat.
    task automatic run1(input int r, g, bl, input bit sof, eol, rs,
                        output int lat);
        b1.in_valid  = 1'b1;
        b1.r_in      = 8'(r);
        b1.g_in      = 8'(g);
        b1.b_in      = 8'(bl);
        b1.in_sof    = sof;
        b1.in_eol    = eol;
        b1.range_sel = rs;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            b1.in_valid = 1'b0;
            b1.in_sof   = 1'b0;
            b1.in_eol   = 1'b0;
            if (b1.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    vec_t tv [11];
    exp_t q [$];

    initial begin
        int lat, y, cb, cr, stale, got, sent, inflight, cyc;
        bit have, st_m, prev_stall, c_sof, c_eol, c_rs;
        int c_r, c_g, c_b;
        logic [26:0] cur, prev;
        exp_t e;

        tv[0]  = '{0, 0, 0, 1, 0, 0, 128, 128};
        tv[1]  = '{255, 255, 255, 0, 0, 255, 128, 128};
        tv[2]  = '{255, 0, 0, 0, 1, 76, 85, 255};
        tv[3]  = '{0, 255, 0, 0, 0, 150, 44, 21};
        tv[4]  = '{0, 0, 255, 0, 0, 29, 255, 107};
        tv[5]  = '{128, 64, 192, 0, 0, 98, 181, 150};
        tv[6]  = '{255, 255, 255, 1, 1, 235, 128, 128};
        tv[7]  = '{0, 0, 0, 0, 0, 16, 128, 128};
        tv[8]  = '{255, 0, 0, 0, 0, 81, 90, 240};
        tv[9]  = '{255, 255, 255, 0, 1, 235, 128, 128};
        tv[10] = '{255, 255, 255, 1, 0, 255, 128, 128};

        b1.in_valid = 0; b1.in_sof = 0; b1.in_eol = 0; b1.range_sel = 0;
        b1.r_in = '0; b1.g_in = '0; b1.b_in = '0; b1.out_ready = 1;
        b4.in_valid = 0; b4.in_sof = 0; b4.in_eol = 0; b4.range_sel = 0;
        b4.r_in = '0; b4.g_in = '0; b4.b_in = '0; b4.out_ready = 1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(b1.out_valid), 0);
        chk("rst_out_sof", int'(b1.out_sof), 0);
        chk("rst_y", int'(b1.y_out), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(b1.in_ready), 1);

        // Directed table: values, latency, mode latching
        for (int i = 0; i < 11; i++) begin
            run1(tv[i].r, tv[i].g, tv[i].b, tv[i].sof, 1'b0, tv[i].rs, lat);
            chk($sformatf("t%0d_lat", i), lat, 3);
            chk($sformatf("t%0d_y", i), int'(b1.y_out), tv[i].y);
            chk($sformatf("t%0d_cb", i), int'(b1.cb_out), tv[i].cb);
            chk($sformatf("t%0d_cr", i), int'(b1.cr_out), tv[i].cr);
            chk($sformatf("t%0d_sof", i), int'(b1.out_sof), int'(tv[i].sof));
        end

        // Random back-pressure with in-order scoreboard
        got = 0; sent = 0; inflight = 0; have = 0; st_m = 0;
        prev_stall = 0; prev = '0;
        c_r = 0; c_g = 0; c_b = 0; c_sof = 0; c_eol = 0; c_rs = 0;
        @(posedge clk);
        for (cyc = 0; cyc < 600 && got < 20; cyc++) begin
            @(negedge clk);
            if (!have && sent < 20) begin
                c_r   = int'($urandom_range(0, 255));
                c_g   = int'($urandom_range(0, 255));
                c_b   = int'($urandom_range(0, 255));
                c_sof = (sent == 0 || sent == 10);
                c_rs  = (sent == 0) ? 1'b1 : (sent == 10) ? 1'b0
                                    : 1'($urandom_range(0, 1));
                c_eol = 1'($urandom_range(0, 1));
                have  = 1;
            end
            b1.in_valid  = have && ($urandom_range(0, 1) == 1);
            b1.r_in      = 8'(c_r);
            b1.g_in      = 8'(c_g);
            b1.b_in      = 8'(c_b);
            b1.in_sof    = c_sof;
            b1.in_eol    = c_eol;
            b1.range_sel = c_rs;
            b1.out_ready = 1'($urandom_range(0, 1));
            #1;
            cur = {b1.out_valid, b1.out_sof, b1.out_eol,
                   b1.y_out, b1.cb_out, b1.cr_out};
            if (prev_stall) chk("bp_hold", int'(cur), int'(prev));
            chk("bp_in_ready", int'(b1.in_ready),
                int'(!(inflight == 3 && !b1.out_ready)));
            if (b1.out_valid && b1.out_ready) begin
                if (q.size() == 0) begin
                    chk("bp_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("bp_y", int'(b1.y_out), e.y);
                    chk("bp_cb", int'(b1.cb_out), e.cb);
                    chk("bp_cr", int'(b1.cr_out), e.cr);
                    chk("bp_side", int'({b1.out_sof, b1.out_eol}),
                        int'({e.sof, e.eol}));
                end
                got++;
                inflight--;
            end
            prev_stall = b1.out_valid && !b1.out_ready;
            prev = cur;
            if (b1.in_valid && b1.in_ready) begin
                if (c_sof) st_m = c_rs;
                model(c_r, c_g, c_b, st_m, y, cb, cr);
                q.push_back('{y, cb, cr, c_sof, c_eol});
                sent++;
                inflight++;
                have = 0;
            end
        end
        chk("bp_done", got, 20);
        @(negedge clk);
        b1.in_valid = 0;
        b1.out_ready = 1;

        // Four lanes, simultaneous sof and eol
        @(posedge clk);
        #1;
        b4.r_in = {8'd128, 8'd255, 8'd255, 8'd0};
        b4.g_in = {8'd64, 8'd0, 8'd255, 8'd0};
        b4.b_in = {8'd192, 8'd0, 8'd255, 8'd0};
        b4.in_sof = 1; b4.in_eol = 1; b4.range_sel = 0; b4.in_valid = 1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            b4.in_valid = 0; b4.in_sof = 0; b4.in_eol = 0;
            if (b4.out_valid) begin
                lat = i;
                break;
            end
        end
        chk("l4_lat", lat, 3);
        chk("l4_y", int'(b4.y_out[23:0]), int'({8'd76, 8'd255, 8'd0}));
        chk("l4_cb", int'(b4.cb_out[23:0]), int'({8'd85, 8'd128, 8'd128}));
        chk("l4_cr", int'(b4.cr_out[23:0]), int'({8'd255, 8'd128, 8'd128}));
        model(128, 64, 192, 1'b0, y, cb, cr);
        chk("l4_lane3_y", int'(b4.y_out[31:24]), y);
        chk("l4_lane3_cb", int'(b4.cb_out[31:24]), cb);
        chk("l4_lane3_cr", int'(b4.cr_out[31:24]), cr);
        chk("l4_sof_eol", int'({b4.out_sof, b4.out_eol}), 3);

        // Fill all stages in studio mode, then reset mid-stream
        @(posedge clk);
        #1;
        b1.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            b1.in_valid = 1;
            b1.r_in = 8'd255; b1.g_in = 8'd255; b1.b_in = 8'd255;
            b1.in_sof = (i == 0); b1.range_sel = 1; b1.in_eol = 0;
            @(posedge clk);
            #1;
        end
        b1.in_valid = 0; b1.in_sof = 0; b1.range_sel = 0;
        #0;
        chk("full_in_ready", int'(b1.in_ready), 0);
        chk("full_out_valid", int'(b1.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(b1.out_valid), 0);
        chk("arst_y", int'(b1.y_out), 0);
        #2;
        rst_n = 1'b1;
        b1.out_ready = 1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (b1.out_valid) stale++;
        end
        chk("arst_stale", stale, 0);
        run1(255, 255, 255, 1'b0, 1'b0, 1'b1, lat);
        chk("arst_lat", lat, 3);
        chk("arst_mode_y", int'(b1.y_out), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
